// File: rtl/ctrl_pkg.sv
// Shared encodings for the PE controller: opcodes, ALU op codes, operand/result selects, FSM states.
package ctrl_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned PC_INC = 4;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_SLL  = 5'd2;
    localparam logic [4:0] ALU_SLT  = 5'd3;
    localparam logic [4:0] ALU_SLTU = 5'd4;
    localparam logic [4:0] ALU_XOR  = 5'd5;
    localparam logic [4:0] ALU_SRL  = 5'd6;
    localparam logic [4:0] ALU_SRA  = 5'd7;
    localparam logic [4:0] ALU_OR   = 5'd8;
    localparam logic [4:0] ALU_AND  = 5'd9;

    localparam logic [1:0] ASEL_REG  = 2'd0;
    localparam logic [1:0] ASEL_PC   = 2'd1;
    localparam logic [1:0] ASEL_ZERO = 2'd2;
    localparam logic [1:0] BSEL_REG  = 2'd0;
    localparam logic [1:0] BSEL_IMM  = 2'd1;
    localparam logic [1:0] BSEL_FOUR = 2'd2;
    localparam logic [1:0] OSEL_REG  = 2'd0;
    localparam logic [1:0] OSEL_MEM  = 2'd1;
    localparam logic [1:0] OSEL_BR   = 2'd2;

    typedef enum logic [2:0] {S_FETCH, S_READ, S_EXEC, S_MEM, S_WB} state_t;

    // ALU op for a supported instruction; M-extension ops land at 16+funct3
    function automatic logic [4:0] alu_decode(input logic [6:0] o, input logic [2:0] f3,
                                              input logic [6:0] f7);
        logic [4:0] sel;
        sel = ALU_ADD;
        if (o == OPC_OP && f7 == F7_MULDIV) begin
            sel = {2'b10, f3};
        end else if (o == OPC_OP || o == OPC_OPIMM) begin
            case (f3)
                3'b000:  sel = (o == OPC_OP && f7[5]) ? ALU_SUB : ALU_ADD;
                3'b001:  sel = ALU_SLL;
                3'b010:  sel = ALU_SLT;
                3'b011:  sel = ALU_SLTU;
                3'b100:  sel = ALU_XOR;
                3'b101:  sel = f7[5] ? ALU_SRA : ALU_SRL;
                3'b110:  sel = ALU_OR;
                default: sel = ALU_AND;
            endcase
        end else if (o == OPC_BRANCH) begin
            case (f3)
                3'b000, 3'b001: sel = ALU_SUB;
                3'b100, 3'b101: sel = ALU_SLT;
                default:        sel = ALU_SLTU;
            endcase
        end
        return sel;
    endfunction

    // BEQ/BGE/BGEU take on a zero ALU result, BNE/BLT/BLTU on non-zero
    function automatic logic branch_taken(input logic [2:0] f3, input logic zero);
        logic t;
        case (f3)
            3'b000, 3'b101, 3'b111: t = zero;
            3'b001, 3'b100, 3'b110: t = !zero;
            default:                t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/ctrl_imm_gen.sv
// Immediate extension: sign-extended imm12, U-type upper immediate, or shift amount for OP-IMM shifts.
module ctrl_imm_gen
    import ctrl_pkg::*;
(
    input  logic [6:0]      op,
    input  logic [2:0]      funct3,
    input  logic [11:0]     imm12,
    input  logic [19:0]     immhi,
    output logic [XLEN-1:0] imm_c
);

    always_comb begin
        imm_c = {{(XLEN-12){imm12[11]}}, imm12};
        if (op == OPC_LUI || op == OPC_AUIPC) begin
            imm_c = {immhi, 12'b0};
        end else if (op == OPC_OPIMM && (funct3 == 3'b001 || funct3 == 3'b101)) begin
            imm_c = XLEN'(imm12[4:0]);
        end
    end

endmodule

// File: rtl/controller.sv
// Multi-cycle PE sequencer: FETCH->READ->EXEC->[MEM]->WB with ready/ack handshakes.
// Optional CTRL_MULDIV_EN adds OP/funct7=0000001 (MUL..REMU) decoding.
module controller
    import ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [6:0]      op,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [1:0]      funct2,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic [4:0]      rd,
    input  logic [11:0]     imm12,
    input  logic [19:0]     immhi,
    input  logic [XLEN-1:0] PCin,
    input  logic [XLEN-1:0] result_1,
    input  logic [XLEN-1:0] result_2,
    input  logic            dataReady,
    input  logic            ALUcomplete,
    input  logic [XLEN-1:0] ALURes,
    input  logic            ALU0,
    input  logic            mem_ack,
    output logic [4:0]      rs1Out,
    output logic [4:0]      rs2Out,
    output logic            Aenable,
    output logic            Benable,
    output logic [XLEN-1:0] Aval,
    output logic [XLEN-1:0] Bval,
    output logic [1:0]      Asel,
    output logic [1:0]      Bsel,
    output logic [4:0]      ALUsel,
    output logic [1:0]      Osel,
    output logic [XLEN-1:0] immvalue,
    output logic            mem_read,
    output logic            mem_write,
    output logic [XLEN-1:0] mem_address,
    output logic [XLEN-1:0] messReg,
    output logic [4:0]      rdOut,
    output logic            rdWrite,
    output logic            reg_select,
    output logic [XLEN-1:0] PCout
);

`ifdef CTRL_MULDIV_EN
    localparam bit MULDIV_EN = 1'b1;
`else
    localparam bit MULDIV_EN = 1'b0;
`endif

    state_t          state;
    logic [6:0]      op_q;
    logic [2:0]      f3_q;
    logic [6:0]      f7_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] imm_c;
    logic            wb_write_c;
    logic            is_mem_c;
    logic            unused_funct2;

    assign unused_funct2 = ^funct2;

    ctrl_imm_gen u_imm_gen (
        .op     (op),
        .funct3 (funct3),
        .imm12  (imm12),
        .immhi  (immhi),
        .imm_c  (imm_c)
    );

    function automatic logic is_supported(input logic [6:0] o, input logic [2:0] f3,
                                          input logic [6:0] f7);
        logic s;
        case (o)
            OPC_LOAD, OPC_OPIMM, OPC_AUIPC, OPC_STORE, OPC_LUI: s = 1'b1;
            OPC_OP:     s = (f7 != F7_MULDIV) || MULDIV_EN;
            OPC_BRANCH: s = (f3 != 3'b010) && (f3 != 3'b011);
            default:    s = 1'b0;
        endcase
        return s;
    endfunction

    assign wb_write_c = (rd_q != 5'd0) &&
                        (op_q == OPC_OPIMM || op_q == OPC_OP || op_q == OPC_LOAD ||
                         op_q == OPC_LUI   || op_q == OPC_AUIPC);
    assign is_mem_c   = (op_q == OPC_LOAD) || (op_q == OPC_STORE);

    // Sequencer; every output is a register updated on state transitions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_FETCH;
            op_q        <= '0;
            f3_q        <= '0;
            f7_q        <= '0;
            rd_q        <= '0;
            pc_q        <= '0;
            rs1Out      <= '0;
            rs2Out      <= '0;
            Aenable     <= 1'b0;
            Benable     <= 1'b0;
            Aval        <= '0;
            Bval        <= '0;
            Asel        <= '0;
            Bsel        <= '0;
            ALUsel      <= '0;
            Osel        <= '0;
            immvalue    <= '0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            messReg     <= '0;
            rdOut       <= '0;
            rdWrite     <= 1'b0;
            reg_select  <= 1'b0;
            PCout       <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    op_q     <= op;
                    f3_q     <= funct3;
                    f7_q     <= funct7;
                    rd_q     <= rd;
                    pc_q     <= PCin;
                    immvalue <= imm_c;
                    if (is_supported(op, funct3, funct7)) begin
                        rs1Out  <= rs1;
                        rs2Out  <= rs2;
                        Aenable <= 1'b1;
                        Benable <= (op == OPC_OP) || (op == OPC_STORE) || (op == OPC_BRANCH);
                        state   <= S_READ;
                    end else begin
                        // Unsupported opcode: skip straight to a non-writing writeback
                        rdOut      <= rd;
                        rdWrite    <= 1'b0;
                        reg_select <= 1'b0;
                        PCout      <= PCin + XLEN'(PC_INC);
                        state      <= S_WB;
                    end
                end
                S_READ: begin
                    if (dataReady) begin
                        Aenable <= 1'b0;
                        Benable <= 1'b0;
                        Aval    <= result_1;
                        Bval    <= result_2;
                        ALUsel  <= alu_decode(op_q, f3_q, f7_q);
                        Asel    <= (op_q == OPC_AUIPC) ? ASEL_PC :
                                   (op_q == OPC_LUI)   ? ASEL_ZERO : ASEL_REG;
                        Bsel    <= (op_q == OPC_OP || op_q == OPC_BRANCH) ? BSEL_REG : BSEL_IMM;
                        Osel    <= is_mem_c ? OSEL_MEM :
                                   (op_q == OPC_BRANCH) ? OSEL_BR : OSEL_REG;
                        state   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (ALUcomplete) begin
                        if (is_mem_c) begin
                            mem_address <= ALURes;
                            mem_read    <= (op_q == OPC_LOAD);
                            mem_write   <= (op_q == OPC_STORE);
                            messReg     <= Bval;
                            state       <= S_MEM;
                        end else begin
                            rdOut      <= rd_q;
                            rdWrite    <= wb_write_c;
                            reg_select <= 1'b0;
                            PCout      <= (op_q == OPC_BRANCH && branch_taken(f3_q, ALU0)) ?
                                          pc_q + immvalue : pc_q + XLEN'(PC_INC);
                            state      <= S_WB;
                        end
                    end
                end
                S_MEM: begin
                    if (mem_ack) begin
                        mem_read   <= 1'b0;
                        mem_write  <= 1'b0;
                        rdOut      <= rd_q;
                        rdWrite    <= wb_write_c;
                        reg_select <= (op_q == OPC_LOAD);
                        PCout      <= pc_q + XLEN'(PC_INC);
                        state      <= S_WB;
                    end
                end
                S_WB: begin
                    rdWrite <= 1'b0;
                    state   <= S_FETCH;
                end
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_controller.sv
// Self-checking bench for controller: directed cases plus randomized instructions against a decode model.
module tb_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  op = '0;
    logic [2:0]  funct3 = '0;
    logic [6:0]  funct7 = '0;
    logic [1:0]  funct2 = '0;
    logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
    logic [11:0] imm12 = '0;
    logic [19:0] immhi = '0;
    logic [31:0] PCin = '0, result_1 = '0, result_2 = '0, ALURes = '0;
    logic        dataReady = 1'b0, ALUcomplete = 1'b0, ALU0 = 1'b0, mem_ack = 1'b0;

    logic [4:0]  rs1Out, rs2Out, ALUsel, rdOut;
    logic        Aenable, Benable, mem_read, mem_write, rdWrite, reg_select;
    logic [31:0] Aval, Bval, immvalue, mem_address, messReg, PCout;
    logic [1:0]  Asel, Bsel, Osel;

    int tests = 0;
    int fails = 0;

    controller dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7(funct7), .funct2(funct2),
        .rs1(rs1), .rs2(rs2), .rd(rd), .imm12(imm12), .immhi(immhi), .PCin(PCin),
        .result_1(result_1), .result_2(result_2), .dataReady(dataReady),
        .ALUcomplete(ALUcomplete), .ALURes(ALURes), .ALU0(ALU0), .mem_ack(mem_ack),
        .rs1Out(rs1Out), .rs2Out(rs2Out), .Aenable(Aenable), .Benable(Benable),
        .Aval(Aval), .Bval(Bval), .Asel(Asel), .Bsel(Bsel), .ALUsel(ALUsel), .Osel(Osel),
        .immvalue(immvalue), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .messReg(messReg), .rdOut(rdOut), .rdWrite(rdWrite),
        .reg_select(reg_select), .PCout(PCout)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          supp, ben, ld, st, wr, br;
        logic [4:0]  alu;
        logic [1:0]  asel, bsel, osel;
        logic [31:0] imm;
    } exp_t;

    // Reference decode from the instruction-set rules
    function automatic exp_t model(input logic [6:0] o, input logic [2:0] f3,
                                   input logic [6:0] f7, input logic [4:0] d,
                                   input logic [11:0] i12, input logic [19:0] ih);
        exp_t e;
        int   tab [8];
        tab = '{0, 2, 3, 4, 5, 6, 8, 9};
        e = '{supp: 0, ben: 0, ld: 0, st: 0, wr: 0, br: 0, alu: 0, asel: 0, bsel: 0, osel: 0, imm: 0};
        e.imm = {{20{i12[11]}}, i12};
        case (o)
            7'h13: begin
                e.supp = 1; e.wr = 1; e.bsel = 1;
                e.alu = 5'(tab[f3] + ((f3 == 3'd5 && f7[5]) ? 1 : 0));
                if (f3 == 3'd1 || f3 == 3'd5) e.imm = 32'(i12[4:0]);
            end
            7'h33: begin
                e.ben = 1; e.wr = 1;
                e.alu = 5'(tab[f3] + (((f3 == 3'd0 || f3 == 3'd5) && f7[5]) ? 1 : 0));
                e.supp = (f7 != 7'd1);
`ifdef CTRL_MULDIV_EN
                if (f7 == 7'd1) begin e.supp = 1; e.alu = 5'(16 + int'(f3)); end
`endif
            end
            7'h03: begin e.supp = 1; e.bsel = 1; e.osel = 1; e.ld = 1; e.wr = 1; end
            7'h23: begin e.supp = 1; e.ben = 1; e.bsel = 1; e.osel = 1; e.st = 1; end
            7'h63: begin
                e.supp = (f3 != 3'd2 && f3 != 3'd3); e.ben = 1; e.br = 1; e.osel = 2;
                e.alu = (f3 < 3'd2) ? 5'd1 : (f3 < 3'd6) ? 5'd3 : 5'd4;
            end
            7'h37: begin e.supp = 1; e.asel = 2; e.bsel = 1; e.wr = 1; e.imm = {ih, 12'b0}; end
            7'h17: begin e.supp = 1; e.asel = 1; e.bsel = 1; e.wr = 1; e.imm = {ih, 12'b0}; end
            default: e.supp = 0;
        endcase
        if (d == 5'd0 || !e.supp) e.wr = 0;
        return e;
    endfunction

    task automatic cyc;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Drives one full instruction with the given handshake delays; starts and ends in FETCH
    task automatic do_instr(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                            input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                            input logic [11:0] i12, input logic [19:0] ih, input logic [31:0] pc,
                            input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] ares,
                            input logic z, input int dly_rd, input int dly_alu, input int dly_mem);
        exp_t        e;
        logic [31:0] exp_pc;
        bit          taken;
        e = model(o, f3, f7, d, i12, ih);
        exp_pc = pc + 32'd4;
        op = o; funct3 = f3; funct7 = f7; funct2 = 2'($urandom); rs1 = s1; rs2 = s2; rd = d;
        imm12 = i12; immhi = ih; PCin = pc;
        dataReady = 0; ALUcomplete = 0; mem_ack = 0;
        cyc();
        if (e.supp) begin
            tests++;
            if ({Aenable, Benable, rs1Out, rs2Out, immvalue} !== {1'b1, e.ben, s1, s2, e.imm}) begin
                fails++;
                $display("FAIL read_strobes op=%h: got aen=%b ben=%b rs1=%0d rs2=%0d imm=%h want aen=1 ben=%b rs1=%0d rs2=%0d imm=%h",
                         o, Aenable, Benable, rs1Out, rs2Out, immvalue, e.ben, s1, s2, e.imm);
            end
            for (int i = 0; i < dly_rd; i++) begin
                ALUcomplete = 1'($urandom); mem_ack = 1'($urandom);
                cyc();
                tests++;
                if (Aenable !== 1'b1) begin
                    fails++; $display("FAIL read_wait: got aen=%b want 1", Aenable);
                end
            end
            ALUcomplete = 0; mem_ack = 0;
            dataReady = 1; result_1 = r1; result_2 = r2;
            cyc();
            dataReady = 0;
            tests++;
            if ({Aenable, Benable, Aval, Bval, ALUsel, Asel, Bsel, Osel} !==
                {2'b00, r1, r2, e.alu, e.asel, e.bsel, e.osel}) begin
                fails++;
                $display("FAIL exec_sel op=%h f3=%0d: got en=%b%b A=%h B=%h alu=%0d as=%0d bs=%0d os=%0d want en=00 A=%h B=%h alu=%0d as=%0d bs=%0d os=%0d",
                         o, f3, Aenable, Benable, Aval, Bval, ALUsel, Asel, Bsel, Osel,
                         r1, r2, e.alu, e.asel, e.bsel, e.osel);
            end
            for (int i = 0; i < dly_alu; i++) begin
                dataReady = 1'($urandom); mem_ack = 1'($urandom);
                cyc();
            end
            dataReady = 0; mem_ack = 0;
            ALUcomplete = 1; ALURes = ares; ALU0 = z;
            cyc();
            ALUcomplete = 0;
            if (e.ld || e.st) begin
                tests++;
                if ({mem_read, mem_write, mem_address} !== {e.ld, e.st, ares} ||
                    (e.st && messReg !== r2)) begin
                    fails++;
                    $display("FAIL mem_req: got rd=%b wr=%b addr=%h data=%h want rd=%b wr=%b addr=%h data=%h",
                             mem_read, mem_write, mem_address, messReg, e.ld, e.st, ares, r2);
                end
                for (int i = 0; i < dly_mem; i++) begin
                    dataReady = 1'($urandom); ALUcomplete = 1'($urandom);
                    cyc();
                    tests++;
                    if ({mem_read, mem_write} !== {e.ld, e.st}) begin
                        fails++;
                        $display("FAIL mem_hold: got rd=%b wr=%b want rd=%b wr=%b", mem_read, mem_write, e.ld, e.st);
                    end
                end
                dataReady = 0; ALUcomplete = 0;
                mem_ack = 1;
                cyc();
                mem_ack = 0;
                tests++;
                if ({mem_read, mem_write} !== 2'b00) begin
                    fails++; $display("FAIL mem_drop: got rd=%b wr=%b want 00", mem_read, mem_write);
                end
            end else if (e.br) begin
                taken = ((f3 == 3'd0) || (f3 == 3'd5) || (f3 == 3'd7)) ? z : !z;
                if (taken) exp_pc = pc + e.imm;
            end
        end else begin
            tests++;
            if ({Aenable, Benable, mem_read, mem_write} !== 4'b0000) begin
                fails++; $display("FAIL unsupported_quiet op=%h: got aen=%b ben=%b mr=%b mw=%b want 0",
                                  o, Aenable, Benable, mem_read, mem_write);
            end
        end
        tests++;
        if ({rdWrite, rdOut, reg_select, PCout} !== {e.wr, d, e.ld, exp_pc}) begin
            fails++;
            $display("FAIL writeback op=%h: got we=%b rd=%0d rsel=%b pc=%h want we=%b rd=%0d rsel=%b pc=%h",
                     o, rdWrite, rdOut, reg_select, PCout, e.wr, d, e.ld, exp_pc);
        end
        cyc();
        tests++;
        if (rdWrite !== 1'b0) begin
            fails++; $display("FAIL wb_pulse: got we=%b want 0", rdWrite);
        end
    endtask

    task automatic test_reset;
        rst_n = 0;
        #12;
        tests++;
        if ({rs1Out, rs2Out, Aenable, Benable, Aval, Bval, Asel, Bsel, ALUsel, Osel, immvalue,
             mem_read, mem_write, mem_address, messReg, rdOut, rdWrite, reg_select, PCout} !== '0) begin
            fails++; $display("FAIL reset_outputs: got nonzero outputs, want all zero");
        end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_directed;
        do_instr(7'h13, 3'd0, 7'd0, 5'd2, 5'd0, 5'd2, 12'd6, 20'd0, 32'h0, 32'h11, 32'h22, 32'h0, 1'b0, 1, 0, 0);
        do_instr(7'h13, 3'd1, 7'd0, 5'd3, 5'd0, 5'd4, 12'd6, 20'd0, 32'h1, 32'h5, 32'h0, 32'h0, 1'b0, 0, 2, 0);
        do_instr(7'h03, 3'd2, 7'd0, 5'd1, 5'd0, 5'd7, 12'h004, 20'd0, 32'h40, 32'hFC, 32'h0, 32'h100, 1'b0, 0, 1, 3);
        do_instr(7'h23, 3'd2, 7'd0, 5'd1, 5'd9, 5'd0, 12'h008, 20'd0, 32'h44, 32'h0, 32'hDEAD, 32'h200, 1'b0, 0, 0, 2);
        do_instr(7'h63, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 12'd8, 20'd0, 32'h20, 32'h3, 32'h3, 32'h0, 1'b1, 0, 0, 0);
        do_instr(7'h63, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 12'd8, 20'd0, 32'h20, 32'h3, 32'h4, 32'h0, 1'b0, 0, 0, 0);
        do_instr(7'h63, 3'd5, 7'd0, 5'd1, 5'd2, 5'd0, 12'hFF8, 20'd0, 32'h80, 32'h0, 32'h0, 32'h0, 1'b1, 1, 1, 0);
        do_instr(7'h33, 3'd0, 7'h20, 5'd5, 5'd6, 5'd8, 12'd0, 20'd0, 32'h100, 32'h9, 32'h4, 32'h0, 1'b0, 0, 0, 0);
        do_instr(7'h33, 3'd0, 7'h01, 5'd5, 5'd6, 5'd8, 12'd0, 20'd0, 32'h104, 32'h9, 32'h4, 32'h0, 1'b0, 0, 0, 0);
        do_instr(7'h37, 3'd0, 7'd0, 5'd0, 5'd0, 5'd10, 12'd0, 20'hABCDE, 32'h108, 32'h0, 32'h0, 32'h0, 1'b0, 0, 0, 0);
        do_instr(7'h17, 3'd0, 7'd0, 5'd0, 5'd0, 5'd11, 12'd0, 20'h00012, 32'h10C, 32'h0, 32'h0, 32'h0, 1'b0, 0, 0, 0);
        do_instr(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 12'd1, 20'd0, 32'h110, 32'h0, 32'h0, 32'h0, 1'b0, 0, 0, 0);
        do_instr(7'h6F, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 12'd0, 20'd0, 32'h114, 32'h0, 32'h0, 32'h0, 1'b0, 0, 0, 0);
    endtask

    task automatic test_random(input int n, input int max_dly);
        logic [6:0] ops [8];
        logic [2:0] bf3 [6];
        logic [6:0] o, f7;
        logic [2:0] f3;
        ops = '{7'h13, 7'h33, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h67};
        bf3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        for (int k = 0; k < n; k++) begin
            o  = ops[$urandom_range(7, 0)];
            f3 = 3'($urandom);
            f7 = 7'($urandom);
            if (o == 7'h63) f3 = bf3[$urandom_range(5, 0)];
            if (o == 7'h33) f7 = (f7[0]) ? 7'h01 : (f7[1] ? 7'h20 : 7'h00);
            do_instr(o, f3, f7, 5'($urandom), 5'($urandom), 5'($urandom), 12'($urandom),
                     20'($urandom), $urandom, $urandom, $urandom, $urandom, 1'($urandom),
                     $urandom_range(max_dly, 0), $urandom_range(max_dly, 0), $urandom_range(max_dly, 0));
        end
    endtask

    task automatic test_reset_in_mem;
        op = 7'h03; funct3 = 3'd2; rs1 = 5'd1; rd = 5'd6; imm12 = 12'd0; PCin = 32'h300;
        cyc();
        dataReady = 1;
        cyc();
        dataReady = 0; ALUcomplete = 1; ALURes = 32'h100;
        cyc();
        ALUcomplete = 0;
        tests++;
        if (mem_read !== 1'b1) begin
            fails++; $display("FAIL reset_mem_setup: got mem_read=%b want 1", mem_read);
        end
        #2 rst_n = 0;
        #1;
        tests++;
        if ({mem_read, mem_write, mem_address} !== '0) begin
            fails++; $display("FAIL reset_mem_drop: got rd=%b wr=%b addr=%h want 0", mem_read, mem_write, mem_address);
        end
        @(negedge clk);
        rst_n = 1;
        do_instr(7'h13, 3'd0, 7'd0, 5'd2, 5'd0, 5'd2, 12'd6, 20'd0, 32'h0, 32'h1, 32'h0, 32'h0, 1'b0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random(40, 3);
        test_random(10, 0);
        test_reset_in_mem();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
